fetch_sequencer: RTL

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_pkg.sv | 18 +
 rtl/pc_unit.sv | 41 ++++
 rtl/fetch_sequencer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch path: FSM state encoding,
// instruction length, and the redirect-target alignment test.
package fetch_pkg;

  localparam int unsigned ILEN = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DELIVER = 2'd2,
    ST_ERR     = 2'd3
  } fetch_state_e;

  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_unit.sv
// Program counter register with next-PC selection (hold / sequential / target).
// The reset input is asynchronous and active-low.
module pc_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_seq,
  input  logic        ld_tgt,
  input  logic [31:0] tgt_pc,
  output logic [31:0] pc,
  output logic [31:0] pc_new
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // Sequential successor wraps naturally modulo 2^32.
  assign pc_new = pc_q + 32'(ILEN);
  assign pc     = pc_q;

  always_comb begin
    pc_d = pc_q;
    if (ld_tgt) begin
      pc_d = tgt_pc;
    end else if (ld_seq) begin
      pc_d = pc_new;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues imem requests at pc, registers the
// returned word for decode, and handles redirects, stalls and ack timeouts.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stall,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_ack,
  input  logic [31:0]  imem_rdata,
  output logic [31:0]  instr,
  output logic         instr_valid,
  output logic [31:0]  pc,
  output logic [31:0]  pc_new,
  output logic [31:0]  fetch_cnt,
  output logic         err,
  output fetch_state_e dbg_state,
  output logic         dbg_pend_redir
);

  localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT);

  // Handshake: imem_req stays high with imem_addr stable until a cycle with
  // imem_ack; imem_ack qualifies imem_rdata for that single cycle only.
  fetch_state_e state_q, state_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  cnt_q, cnt_d;
  logic [31:0]  wait_q, wait_d;
  logic [31:0]  tgt_q, tgt_d;
  logic         pend_q, pend_d;
  logic         pc_ld_seq, pc_ld_tgt;
  logic [31:0]  pc_tgt;

  pc_unit #(.RESET_PC(RESET_PC)) u_pc (
    .clk    (clk),
    .reset  (reset),
    .ld_seq (pc_ld_seq),
    .ld_tgt (pc_ld_tgt),
    .tgt_pc (pc_tgt),
    .pc     (pc),
    .pc_new (pc_new)
  );

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    cnt_d     = cnt_q;
    wait_d    = wait_q;
    tgt_d     = tgt_q;
    pend_d    = pend_q;
    pc_ld_seq = 1'b0;
    pc_ld_tgt = 1'b0;
    pc_tgt    = redirect_pc;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_REQ;
          wait_d  = '0;
        end
      end
      ST_REQ: begin
        if (redirect && misaligned(redirect_pc)) begin
          state_d = ST_ERR;
        end else if (imem_ack) begin
          // Data answering a superseded address is dropped; refetch at the target.
          if (redirect || pend_q) begin
            pc_ld_tgt = 1'b1;
            pc_tgt    = redirect ? redirect_pc : tgt_q;
            pend_d    = 1'b0;
            wait_d    = '0;
          end else begin
            instr_d = imem_rdata;
            state_d = ST_DELIVER;
          end
        end else begin
          if (redirect) begin
            pend_d = 1'b1;
            tgt_d  = redirect_pc;
          end
          wait_d = wait_q + 32'd1;
          if (wait_d == TIMEOUT_W) begin
            state_d = ST_ERR;
          end
        end
      end
      ST_DELIVER: begin
        if (!stall) begin
          cnt_d = cnt_q + 32'd1;
          if (redirect && misaligned(redirect_pc)) begin
            state_d = ST_ERR;
          end else begin
            pc_ld_tgt = redirect;
            pc_ld_seq = !redirect;
            state_d   = ST_REQ;
            wait_d    = '0;
          end
        end
      end
      default: begin
        state_d = ST_ERR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      cnt_q   <= '0;
      wait_q  <= '0;
      tgt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      tgt_q   <= tgt_d;
      pend_q  <= pend_d;
    end
  end

  assign imem_req       = (state_q == ST_REQ);
  assign imem_addr      = pc;
  assign instr          = instr_q;
  assign instr_valid    = (state_q == ST_DELIVER);
  assign fetch_cnt      = cnt_q;
  assign err            = (state_q == ST_ERR);
  assign dbg_state      = state_q;
  assign dbg_pend_redir = pend_q;

endmodule
